// File: rtl/mole_game_ctrl.sv
// mole_game_ctrl: whack-a-mole controller feeding the VGA stage (slot picker, press judge, BCD score).
// Optional build macro MOLE_SCORE_PENALTY_EN: every miss or timeout also takes one point off the score.
module mole_game_ctrl #(
    parameter int         MOLE_UP_CYCLES = 100000000,
    parameter int         LOCKOUT_CYCLES = 20000000,
    parameter int         CNT_W          = 28,
    parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] btn_press,
    output logic [2:0] mole_position,
    output logic [3:0] digit_1,
    output logic [3:0] digit_2,
    output logic       guess_correct,
    output logic       guess_wrong
);

    localparam logic [1:0] ST_SPAWN   = 2'd0;
    localparam logic [1:0] ST_UP      = 2'd1;
    localparam logic [1:0] ST_LOCKOUT = 2'd2;

    localparam logic [CNT_W-1:0] UP_LAST   = CNT_W'(MOLE_UP_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] counter;
    logic [7:0]       lfsr;
    logic             lfsr_fb;
    logic             hit_pending;
    logic             miss_pending;

    logic [2:0]       raw_slot;
    logic [2:0]       base_slot;
    logic [2:0]       spawn_slot;
    logic [4:0]       target_mask;
    logic             press_any;
    logic             press_hit;
    logic             timeout;

    function automatic logic [7:0] bcd_inc(input logic [7:0] score);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = score[7:4];
        ones = score[3:0];
        if (ones >= 4'd9) begin
            ones = 4'd0;
            tens = (tens >= 4'd9) ? 4'd0 : tens + 4'd1;
        end else begin
            ones = ones + 4'd1;
        end
        return {tens, ones};
    endfunction

`ifdef MOLE_SCORE_PENALTY_EN
    function automatic logic [7:0] bcd_dec(input logic [7:0] score);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = score[7:4];
        ones = score[3:0];
        if (score == 8'h00) begin
            tens = 4'd0;
            ones = 4'd0;
        end else if (ones == 4'd0) begin
            ones = 4'd9;
            tens = tens - 4'd1;
        end else begin
            ones = ones - 4'd1;
        end
        return {tens, ones};
    endfunction
`endif

    // Fold the 3-bit LFSR sample onto 0..4 and bump it if it would repeat the current slot.
    always_comb begin
        raw_slot  = lfsr[2:0];
        base_slot = (raw_slot >= 3'd5) ? raw_slot - 3'd5 : raw_slot;
        if (base_slot == mole_position) begin
            spawn_slot = (base_slot == 3'd4) ? 3'd0 : base_slot + 3'd1;
        end else begin
            spawn_slot = base_slot;
        end
    end

    assign target_mask = 5'd1 << mole_position;
    assign press_any   = |btn_press;
    assign press_hit   = (btn_press == target_mask);
    assign timeout     = (counter == UP_LAST);
    assign lfsr_fb     = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[6:0], lfsr_fb};
        end
    end

    // The verdict is parked in *_pending for one cycle so pulses and score land one edge after the decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_SPAWN;
            counter       <= '0;
            mole_position <= 3'd0;
            hit_pending   <= 1'b0;
            miss_pending  <= 1'b0;
        end else begin
            hit_pending  <= 1'b0;
            miss_pending <= 1'b0;
            case (state)
                ST_SPAWN: begin
                    mole_position <= spawn_slot;
                    counter       <= '0;
                    state         <= ST_UP;
                end
                ST_UP: begin
                    if (press_any) begin
                        hit_pending  <= press_hit;
                        miss_pending <= ~press_hit;
                        counter      <= '0;
                        state        <= ST_LOCKOUT;
                    end else if (timeout) begin
                        miss_pending <= 1'b1;
                        counter      <= '0;
                        state        <= ST_LOCKOUT;
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                ST_LOCKOUT: begin
                    if (counter == LOCK_LAST) begin
                        counter <= '0;
                        state   <= ST_SPAWN;
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                default: begin
                    counter <= '0;
                    state   <= ST_SPAWN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            guess_correct <= 1'b0;
            guess_wrong   <= 1'b0;
            digit_1       <= 4'd0;
            digit_2       <= 4'd0;
        end else begin
            guess_correct <= hit_pending;
            guess_wrong   <= miss_pending;
            if (hit_pending) begin
                {digit_1, digit_2} <= bcd_inc({digit_1, digit_2});
            end
`ifdef MOLE_SCORE_PENALTY_EN
            else if (miss_pending) begin
                {digit_1, digit_2} <= bcd_dec({digit_1, digit_2});
            end
`endif
        end
    end

endmodule
